// File: rtl/csa_pipe_addsub.sv
// csa_pipe_addsub: two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Optional SATURATE_EN clamps the result to the signed limits on overflow.
module csa_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N = WIDTH / BLOCK;
    logic [WIDTH-1:0] w_b_eff, w_s0, w_s1, w_sum, w_res;
    logic [N-1:0]     w_co0, w_co1;
    logic             w_c_eff, w_carry, w_ovf, w_adv, w_acc;
    logic [WIDTH-1:0] r_s0, r_s1, r_sum;
    logic [N-1:0]     r_co0, r_co1;
    logic             r_c_eff, r_a_msb, r_b_msb, r_s1_valid, r_s2_valid, r_cout, r_ovf, r_zero;
    assign w_b_eff  = b ^ {WIDTH{sub}};
    assign w_c_eff  = sub | cin;
    assign w_adv    = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready = !r_s1_valid || w_adv;
    assign w_acc    = in_valid && in_ready;
    // Each block speculatively computes both carry-in outcomes in stage 1.
    for (genvar k = 0; k < N; k++) begin : g_blk
        assign {w_co0[k], w_s0[k*BLOCK +: BLOCK]} =
            {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, w_b_eff[k*BLOCK +: BLOCK]};
        assign {w_co1[k], w_s1[k*BLOCK +: BLOCK]} =
            {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, w_b_eff[k*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
    end
    always_comb begin
        w_sum   = '0;
        w_carry = r_c_eff;
        for (int k = 0; k < N; k++) begin
            w_sum[k*BLOCK +: BLOCK] = w_carry ? r_s1[k*BLOCK +: BLOCK] : r_s0[k*BLOCK +: BLOCK];
            w_carry = w_carry ? r_co1[k] : r_co0[k];
        end
    end
    assign w_ovf = (r_a_msb == r_b_msb) && (w_sum[WIDTH-1] != r_a_msb);
`ifdef SATURATE_EN
    assign w_res = w_ovf ? {r_a_msb, {(WIDTH-1){!r_a_msb}}} : w_sum;
`else
    assign w_res = w_sum;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s0       <= '0;
            r_s1       <= '0;
            r_co0      <= '0;
            r_co1      <= '0;
            r_c_eff    <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
        end else if (w_acc) begin
            r_s1_valid <= 1'b1;
            r_s0       <= w_s0;
            r_s1       <= w_s1;
            r_co0      <= w_co0;
            r_co1      <= w_co1;
            r_c_eff    <= w_c_eff;
            r_a_msb    <= a[WIDTH-1];
            r_b_msb    <= w_b_eff[WIDTH-1];
        end else if (w_adv) begin
            r_s1_valid <= 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= 1'b1;
            r_sum      <= w_res;
            r_cout     <= w_carry;
            r_ovf      <= w_ovf;
            r_zero     <= (w_res == '0);
        end else if (r_s2_valid && out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end
    assign out_valid = r_s2_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule
